// File: rtl/dual_port_ram_rd_arb_if.sv
// dual_port_ram_rd_arb_if: two-client read request/response bus plus the RAM read-port signals.
// slave is the arbiter side; master is the clients-and-RAM side.
interface dual_port_ram_rd_arb_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic                  req0_ready;
   logic                  resp0_valid;
   logic [DATA_WIDTH-1:0] resp0_data;
   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic                  req1_ready;
   logic                  resp1_valid;
   logic [DATA_WIDTH-1:0] resp1_data;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic                  ram_rd;
   logic                  ram_output_reg_en;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr, ram_rd_data,
      output req0_ready, resp0_valid, resp0_data, req1_ready, resp1_valid, resp1_data,
             ram_rd_addr, ram_rd, ram_output_reg_en
   );
   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr, ram_rd_data,
      input  req0_ready, resp0_valid, resp0_data, req1_ready, resp1_valid, resp1_data,
             ram_rd_addr, ram_rd, ram_output_reg_en
   );
endinterface

// File: rtl/dual_port_ram_rd_arb.sv
// dual_port_ram_rd_arb: two-client read arbiter for one dual_port_ram read port, tag pipeline steers data back.
// Define RAM_ARB_RR_EN for round-robin on contention; otherwise client 0 has fixed priority.
module dual_port_ram_rd_arb #(
   parameter int DATA_WIDTH        = 8,
   parameter int ADDR_WIDTH        = 5,
   parameter int REGISTERED_OUTPUT = 1
) (
   input logic                   i_clk,
   input logic                   i_rst,
   dual_port_ram_rd_arb_if.slave s_bus
);
   localparam int LAT = 1 + REGISTERED_OUTPUT;
   logic                  w_g0, w_g1, w_acc;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [LAT-1:0]        r_vld, r_id;
`ifdef RAM_ARB_RR_EN
   logic r_last_grant;
   always_ff @(posedge i_clk)
      if (i_rst) r_last_grant <= 1'b1;
      else if (w_acc) r_last_grant <= w_g1;
   assign w_g0 = ~i_rst & s_bus.req0_valid & (~s_bus.req1_valid | r_last_grant);
   assign w_g1 = ~i_rst & s_bus.req1_valid & (~s_bus.req0_valid | ~r_last_grant);
`else
   assign w_g0 = ~i_rst & s_bus.req0_valid;
   assign w_g1 = ~i_rst & s_bus.req1_valid & ~s_bus.req0_valid;
`endif
   assign w_acc  = w_g0 | w_g1;
   assign w_addr = w_g0 ? s_bus.req0_addr : w_g1 ? s_bus.req1_addr : '0;
   assign w_data = s_bus.ram_rd_data;
   // Stage 0 takes this cycle's grant; the top stage lines up with the RAM's data.
   always_ff @(posedge i_clk)
      if (i_rst) begin
         r_vld <= '0;
         r_id  <= '0;
      end else begin
         r_vld <= LAT'({r_vld, w_acc});
         r_id  <= LAT'({r_id, w_g1});
      end
   assign s_bus.req0_ready        = w_g0;
   assign s_bus.req1_ready        = w_g1;
   assign s_bus.ram_rd            = s_bus.req0_valid | s_bus.req1_valid;
   assign s_bus.ram_rd_addr       = w_addr;
   assign s_bus.ram_output_reg_en = 1'b1;
   assign s_bus.resp0_valid       = ~i_rst & r_vld[LAT-1] & ~r_id[LAT-1];
   assign s_bus.resp1_valid       = ~i_rst & r_vld[LAT-1] & r_id[LAT-1];
   assign s_bus.resp0_data        = w_data;
   assign s_bus.resp1_data        = w_data;
endmodule

// File: tb/tb_dual_port_ram_rd_arb.sv
// tb_dual_port_ram_rd_arb: directed checks of the read arbiter against a behavioural RAM with mem[a] = a + 8'h40.
// u_dut has a registered-output RAM (latency 2); u_dut1 has an unregistered one (latency 1).
module tb_dual_port_ram_rd_arb;
`ifdef RAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   logic [7:0] ram2_q1, ram2_q2, ram1_q1;
   dual_port_ram_rd_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus2 ();
   dual_port_ram_rd_arb_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus1 ();
   dual_port_ram_rd_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .REGISTERED_OUTPUT(1)) u_dut (
      .i_clk(clk), .i_rst(rst), .s_bus(bus2));
   dual_port_ram_rd_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .REGISTERED_OUTPUT(0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .s_bus(bus1));
   always #5 clk = ~clk;
   always_ff @(posedge clk) begin
      if (bus2.ram_rd) ram2_q1 <= {3'b000, bus2.ram_rd_addr} + 8'h40;
      if (bus2.ram_output_reg_en) ram2_q2 <= ram2_q1;
      if (bus1.ram_rd) ram1_q1 <= {3'b000, bus1.ram_rd_addr} + 8'h40;
   end
   assign bus2.ram_rd_data = ram2_q2;
   assign bus1.ram_rd_data = ram1_q1;

   task automatic drive(input logic v0, input logic [4:0] a0, input logic v1, input logic [4:0] a1);
      bus2.req0_valid = v0;
      bus2.req0_addr  = a0;
      bus2.req1_valid = v1;
      bus2.req1_addr  = a1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 5'd4, 1'b1, 5'd6);
      @(negedge clk);
      n_total++; if (bus2.req0_ready !== 1'b0) $display("FAIL rst_ready0 got %b exp 0", bus2.req0_ready); else n_pass++;
      n_total++; if (bus2.req1_ready !== 1'b0) $display("FAIL rst_ready1 got %b exp 0", bus2.req1_ready); else n_pass++;
      n_total++; if (bus2.ram_output_reg_en !== 1'b1) $display("FAIL rst_oreg_en got %b exp 1", bus2.ram_output_reg_en); else n_pass++;
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      n_total++; if (bus2.req0_ready !== 1'b0) $display("FAIL idle_ready0 got %b exp 0", bus2.req0_ready); else n_pass++;
      n_total++; if (bus2.req1_ready !== 1'b0) $display("FAIL idle_ready1 got %b exp 0", bus2.req1_ready); else n_pass++;
      n_total++; if (bus2.resp0_valid !== 1'b0) $display("FAIL idle_resp0_valid got %b exp 0", bus2.resp0_valid); else n_pass++;
      n_total++; if (bus2.resp1_valid !== 1'b0) $display("FAIL idle_resp1_valid got %b exp 0", bus2.resp1_valid); else n_pass++;
      n_total++; if (bus2.ram_rd_addr !== 5'd0) $display("FAIL idle_addr got %0d exp 0", bus2.ram_rd_addr); else n_pass++;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c <= 34; c++) begin
         drive(c < 32, 5'(c), 1'b0, 5'd0);
         @(negedge clk);
         if (c < 32) begin
            n_total++; if (bus2.req0_ready !== 1'b1) $display("FAIL b2b_ready0 c=%0d got %b exp 1", c, bus2.req0_ready); else n_pass++;
            n_total++; if (bus2.ram_rd_addr !== 5'(c)) $display("FAIL b2b_addr c=%0d got %0d exp %0d", c, bus2.ram_rd_addr, c); else n_pass++;
         end
         if (c >= 2 && c < 34) begin
            n_total++; if (bus2.resp0_valid !== 1'b1) $display("FAIL b2b_resp0_valid c=%0d got %b exp 1", c, bus2.resp0_valid); else n_pass++;
            n_total++; if (bus2.resp0_data !== 8'(8'h40 + c - 2)) $display("FAIL b2b_resp0_data c=%0d got %h exp %h", c, bus2.resp0_data, 8'(8'h40 + c - 2)); else n_pass++;
         end else begin
            n_total++; if (bus2.resp0_valid !== 1'b0) $display("FAIL b2b_resp0_idle c=%0d got %b exp 0", c, bus2.resp0_valid); else n_pass++;
         end
         n_total++; if (bus2.resp1_valid !== 1'b0) $display("FAIL b2b_resp1_valid c=%0d got %b exp 0", c, bus2.resp1_valid); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_contention();
      logic g0, pg0;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         drive(c < 8, 5'd3, c < 8, 5'd7);
         g0  = !RR || (c % 2 == 0);
         pg0 = !RR || ((c - 2) % 2 == 0);
         @(negedge clk);
         if (c < 8) begin
            n_total++; if (bus2.req0_ready !== g0) $display("FAIL arb_ready0 c=%0d got %b exp %b", c, bus2.req0_ready, g0); else n_pass++;
            n_total++; if (bus2.req1_ready !== !g0) $display("FAIL arb_ready1 c=%0d got %b exp %b", c, bus2.req1_ready, !g0); else n_pass++;
            n_total++; if (bus2.ram_rd_addr !== (g0 ? 5'd3 : 5'd7)) $display("FAIL arb_addr c=%0d got %0d exp %0d", c, bus2.ram_rd_addr, g0 ? 3 : 7); else n_pass++;
         end
         if (c >= 2 && c < 10) begin
            n_total++; if (bus2.resp0_valid !== pg0) $display("FAIL arb_resp0_valid c=%0d got %b exp %b", c, bus2.resp0_valid, pg0); else n_pass++;
            n_total++; if (bus2.resp1_valid !== !pg0) $display("FAIL arb_resp1_valid c=%0d got %b exp %b", c, bus2.resp1_valid, !pg0); else n_pass++;
            n_total++; if (bus2.resp0_data !== (pg0 ? 8'h43 : 8'h47)) $display("FAIL arb_data c=%0d got %h exp %h", c, bus2.resp0_data, pg0 ? 8'h43 : 8'h47); else n_pass++;
         end else begin
            n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== 2'b00) $display("FAIL arb_resp_idle c=%0d got %b%b exp 00", c, bus2.resp0_valid, bus2.resp1_valid); else n_pass++;
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      drive(1'b0, 5'd0, 1'b1, 5'd9);
      @(negedge clk);
      n_total++; if (bus2.req1_ready !== 1'b1) $display("FAIL mid_a_ready1 got %b exp 1", bus2.req1_ready); else n_pass++;
      next_cycle();
      drive(1'b1, 5'd5, 1'b0, 5'd0);
      @(negedge clk);
      n_total++; if (bus2.req0_ready !== 1'b1) $display("FAIL mid_b_ready0 got %b exp 1", bus2.req0_ready); else n_pass++;
      next_cycle();
      rst = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 5'd9);
      @(negedge clk);
      n_total++; if ({bus2.req0_ready, bus2.req1_ready} !== 2'b00) $display("FAIL mid_rst_ready got %b%b exp 00", bus2.req0_ready, bus2.req1_ready); else n_pass++;
      n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== 2'b00) $display("FAIL mid_rst_resp got %b%b exp 00", bus2.resp0_valid, bus2.resp1_valid); else n_pass++;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_total++; if ({bus2.req0_ready, bus2.req1_ready} !== 2'b10) $display("FAIL mid_post_ready got %b%b exp 10", bus2.req0_ready, bus2.req1_ready); else n_pass++;
      n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== 2'b00) $display("FAIL mid_drop_d got %b%b exp 00", bus2.resp0_valid, bus2.resp1_valid); else n_pass++;
      next_cycle();
      drive(1'b0, 5'd0, 1'b0, 5'd0);
      @(negedge clk);
      n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== 2'b00) $display("FAIL mid_drop_e got %b%b exp 00", bus2.resp0_valid, bus2.resp1_valid); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== 2'b10) $display("FAIL mid_post_resp got %b%b exp 10", bus2.resp0_valid, bus2.resp1_valid); else n_pass++;
      n_total++; if (bus2.resp0_data !== 8'h45) $display("FAIL mid_post_data got %h exp 45", bus2.resp0_data); else n_pass++;
      next_cycle();
   endtask

   task automatic test_lat1();
      do_reset();
      bus1.req1_valid = 1'b1;
      bus1.req1_addr  = 5'd31;
      @(negedge clk);
      n_total++; if (bus1.req1_ready !== 1'b1) $display("FAIL lat1_ready1 got %b exp 1", bus1.req1_ready); else n_pass++;
      n_total++; if (bus1.resp1_valid !== 1'b0) $display("FAIL lat1_early got %b exp 0", bus1.resp1_valid); else n_pass++;
      next_cycle();
      bus1.req1_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus1.resp1_valid !== 1'b1) $display("FAIL lat1_resp1_valid got %b exp 1", bus1.resp1_valid); else n_pass++;
      n_total++; if (bus1.resp1_data !== 8'h5F) $display("FAIL lat1_resp1_data got %h exp 5f", bus1.resp1_data); else n_pass++;
      n_total++; if (bus1.resp0_valid !== 1'b0) $display("FAIL lat1_resp0_valid got %b exp 0", bus1.resp0_valid); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_total++; if (bus1.resp1_valid !== 1'b0) $display("FAIL lat1_late got %b exp 0", bus1.resp1_valid); else n_pass++;
      next_cycle();
   endtask

   task automatic test_random();
      logic       v0, v1, g0, g1, m_last;
      logic [4:0] a0, a1;
      logic [1:0] pv, pid;
      logic [7:0] pd0, pd1;
      do_reset();
      m_last = 1'b1;
      pv = 2'b00;
      pid = 2'b00;
      pd0 = 8'h00;
      pd1 = 8'h00;
      for (int c = 0; c < 400; c++) begin
         v0 = (c < 396) && ($urandom_range(0, 3) != 0);
         v1 = (c < 396) && ($urandom_range(0, 3) != 0);
         a0 = 5'($urandom);
         a1 = 5'($urandom);
         drive(v0, a0, v1, a1);
         g0 = v0 && (!RR || !v1 || m_last);
         g1 = v1 && !g0;
         @(negedge clk);
         n_total++; if ({bus2.req0_ready, bus2.req1_ready} !== {g0, g1}) $display("FAIL rnd_ready c=%0d got %b%b exp %b%b", c, bus2.req0_ready, bus2.req1_ready, g0, g1); else n_pass++;
         n_total++; if ({bus2.resp0_valid, bus2.resp1_valid} !== {pv[1] & !pid[1], pv[1] & pid[1]}) $display("FAIL rnd_resp_valid c=%0d got %b%b exp %b%b", c, bus2.resp0_valid, bus2.resp1_valid, pv[1] & !pid[1], pv[1] & pid[1]); else n_pass++;
         if (pv[1]) begin
            n_total++; if ((pid[1] ? bus2.resp1_data : bus2.resp0_data) !== pd1) $display("FAIL rnd_data c=%0d got %h exp %h", c, pid[1] ? bus2.resp1_data : bus2.resp0_data, pd1); else n_pass++;
         end
         pv  = {pv[0], g0 | g1};
         pid = {pid[0], g1};
         pd1 = pd0;
         pd0 = {3'b000, g1 ? a1 : a0} + 8'h40;
         if (g0 | g1) m_last = g1;
         next_cycle();
      end
   endtask

   initial begin
      drive(1'b0, 5'd0, 1'b0, 5'd0);
      bus1.req0_valid = 1'b0;
      bus1.req0_addr  = 5'd0;
      bus1.req1_valid = 1'b0;
      bus1.req1_addr  = 5'd0;
      test_reset();
      test_back_to_back();
      test_contention();
      test_reset_midflight();
      test_lat1();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
